// File: rtl/dsm_rx_demod.sv
// dsm_rx_demod
// Receive-side demodulator for one element's 2-bit delta-sigma stream.
// The 3-level code is mixed with the quarter-rate LO (the same sequence the
// transmit mixer uses). Each branch then goes through an order-3 CIC
// decimator that produces signed I/Q.
//
// Ports
//   clock      system clock
//   reset      asynchronous, active-low reset
//   in_valid   qualifies pwm_in; no state advances while low
//   pwm_in     DSM code: 01 = +1, 00 = 0, 11 = -1, 10 = illegal (treated as 0)
//   lo_sync    with in_valid: LO phase 0 and decimation count 0 for this sample
//   err_clr    clears code_err (a coincident illegal code wins)
//   i_out      signed decimated I, held between strobes
//   q_out      signed decimated Q, held between strobes
//   out_valid  one-cycle strobe marking new i_out/q_out
//   code_err   sticky illegal-code flag
module dsm_rx_demod #(
    parameter int LOG2R = 4,
    parameter int OUT_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [1:0]              pwm_in,
    input  logic                    lo_sync,
    input  logic                    err_clr,
    output logic signed [OUT_W-1:0] i_out,
    output logic signed [OUT_W-1:0] q_out,
    output logic                    out_valid,
    output logic                    code_err
);

    localparam int W  = 3*LOG2R + 2;
    localparam int SH = 3*LOG2R - 8;
    localparam logic [LOG2R-1:0] D_LAST = '1;
    localparam logic signed [W-1:0] SAT_HI = W'((2**(OUT_W-1)) - 1);
    localparam logic signed [W-1:0] SAT_LO = -SAT_HI - W'(1);

    logic [1:0]              p_q, p_d;
    logic [LOG2R-1:0]        d_q, d_d;
    logic signed [W-1:0]     i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
    logic signed [W-1:0]     q1_q, q2_q, q3_q, q1_d, q2_d, q3_d;
    logic signed [W-1:0]     zi1_q, zi2_q, zi3_q, zi1_d, zi2_d, zi3_d;
    logic signed [W-1:0]     zq1_q, zq2_q, zq3_q, zq1_d, zq2_d, zq3_d;
    logic signed [OUT_W-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
    logic                    out_valid_q, out_valid_d;
    logic                    code_err_q, code_err_d;

    logic [1:0]              p_cur;
    logic [LOG2R-1:0]        d_cur;
    logic signed [W-1:0]     x, mi, mq;
    logic signed [W-1:0]     ci1, ci2, ci3, cq1, cq2, cq3;
    logic                    strobe;

    function automatic logic signed [OUT_W-1:0] scale_sat(input logic signed [W-1:0] v);
        logic signed [W-1:0] s;
        s = v >>> SH;
        if (s > SAT_HI) begin
            s = SAT_HI;
        end else if (s < SAT_LO) begin
            s = SAT_LO;
        end
        return s[OUT_W-1:0];
    endfunction

    always_comb begin
        // lo_sync realigns phase and block boundary for the current sample
        p_cur = lo_sync ? 2'd0 : p_q;
        d_cur = lo_sync ? '0 : d_q;

        case (pwm_in)
            2'b01:   x = W'(1);
            2'b11:   x = '1;
            default: x = '0;
        endcase

        // LO_i = +1,0,-1,0 and LO_q = 0,+1,0,-1 over phases 0..3
        case (p_cur)
            2'd0:    begin mi = x;   mq = '0;  end
            2'd1:    begin mi = '0;  mq = x;   end
            2'd2:    begin mi = -x;  mq = '0;  end
            default: begin mi = '0;  mq = -x;  end
        endcase

        strobe = in_valid && (d_cur == D_LAST);

        // comb sections work on the pre-edge last integrator
        ci1 = i3_q - zi1_q;
        ci2 = ci1 - zi2_q;
        ci3 = ci2 - zi3_q;
        cq1 = q3_q - zq1_q;
        cq2 = cq1 - zq2_q;
        cq3 = cq2 - zq3_q;

        p_d = p_q;
        d_d = d_q;
        i1_d = i1_q; i2_d = i2_q; i3_d = i3_q;
        q1_d = q1_q; q2_d = q2_q; q3_d = q3_q;
        zi1_d = zi1_q; zi2_d = zi2_q; zi3_d = zi3_q;
        zq1_d = zq1_q; zq2_d = zq2_q; zq3_d = zq3_q;
        i_out_d = i_out_q;
        q_out_d = q_out_q;
        out_valid_d = 1'b0;

        if (in_valid) begin
            p_d = p_cur + 2'd1;
            d_d = d_cur + LOG2R'(1);
            i1_d = i1_q + mi;
            i2_d = i2_q + i1_q;
            i3_d = i3_q + i2_q;
            q1_d = q1_q + mq;
            q2_d = q2_q + q1_q;
            q3_d = q3_q + q2_q;
        end

        if (strobe) begin
            zi1_d = i3_q; zi2_d = ci1; zi3_d = ci2;
            zq1_d = q3_q; zq2_d = cq1; zq3_d = cq2;
            i_out_d = scale_sat(ci3);
            q_out_d = scale_sat(cq3);
            out_valid_d = 1'b1;
        end

        // a new illegal code takes priority over a clear in the same cycle
        if (in_valid && (pwm_in == 2'b10)) begin
            code_err_d = 1'b1;
        end else if (err_clr) begin
            code_err_d = 1'b0;
        end else begin
            code_err_d = code_err_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_q <= '0;
            d_q <= '0;
            i1_q <= '0; i2_q <= '0; i3_q <= '0;
            q1_q <= '0; q2_q <= '0; q3_q <= '0;
            zi1_q <= '0; zi2_q <= '0; zi3_q <= '0;
            zq1_q <= '0; zq2_q <= '0; zq3_q <= '0;
            i_out_q <= '0;
            q_out_q <= '0;
            out_valid_q <= 1'b0;
            code_err_q <= 1'b0;
        end else begin
            p_q <= p_d;
            d_q <= d_d;
            i1_q <= i1_d; i2_q <= i2_d; i3_q <= i3_d;
            q1_q <= q1_d; q2_q <= q2_d; q3_q <= q3_d;
            zi1_q <= zi1_d; zi2_q <= zi2_d; zi3_q <= zi3_d;
            zq1_q <= zq1_d; zq2_q <= zq2_d; zq3_q <= zq3_d;
            i_out_q <= i_out_d;
            q_out_q <= q_out_d;
            out_valid_q <= out_valid_d;
            code_err_q <= code_err_d;
        end
    end

    assign i_out     = i_out_q;
    assign q_out     = q_out_q;
    assign out_valid = out_valid_q;
    assign code_err  = code_err_q;

endmodule

// File: doc/dsm_rx_demod.md
Name: dsm_rx_demod

Overview:
- Receive-side counterpart of the per-element DSM transmit chain (interp -> phase shift -> IQ mixer -> delta-sigma modulator).
- Takes one element's 2-bit DSM output stream and maps it to a 3-level signed sample.
- Down-mixes that sample with the same quarter-rate LO sequence the transmit mixer uses, then CIC-decimates to recover signed 8-bit I/Q.
- Used for loopback self-test and element calibration; one instance per monitored channel.

Parameters:
- LOG2R, 4, log2 of the decimation ratio R (R = 16); legal range 3..6.
- OUT_W, 8, width of the signed I/Q outputs.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  qualifies pwm_in; all state advances only when high
- pwm_in  in  2  DSM code: 2'b01 = +1, 2'b00 = 0, 2'b11 = -1, 2'b10 = illegal
- lo_sync  in  1  with in_valid: forces LO phase 0 and decimation count 0 for this sample
- err_clr  in  1  clears code_err
- i_out  out  OUT_W  signed decimated I
- q_out  out  OUT_W  signed decimated Q
- out_valid  out  1  one-cycle strobe, new i_out/q_out
- code_err  out  1  sticky illegal-code flag

Behaviour:
- Reset (reset low, async): i_out = 0, q_out = 0, out_valid = 0, code_err = 0; LO phase, decimation counter, integrators and comb delays all cleared. Reset mid-block discards the partial block; no out_valid until a full R samples have been accepted after release.
- Code map: x = +1 / 0 / -1. 2'b10 gives x = 0 and sets code_err on that edge.
- code_err holds until err_clr. If err_clr and a new illegal code occur in the same cycle, the set wins.
- LO phase p is a 2-bit counter advancing once per accepted sample.
  - p = 0..3 gives LO_i = +1, 0, -1, 0 and LO_q = 0, +1, 0, -1.
  - When lo_sync accompanies the sample, p = 0 for that sample and the next accepted sample uses p = 1.
- Mixed samples: mi = x*LO_i, mq = x*LO_q, each in {-1, 0, +1}.
- CIC, per branch, order 3, integrator width W = 3*LOG2R + 2, two's-complement wrap permitted (no saturation inside the CIC).
  - On each accepted sample: a1 <= a1 + m; a2 <= a2 + a1; a3 <= a3 + a2. Each stage uses the pre-edge register values.
- Decimation counter d runs 0..R-1 per accepted sample; lo_sync forces d = 0 for the current sample.
- The strobe is the accepted sample with d = R-1.
  - On that edge the comb chain evaluates combinationally from the pre-edge a3: c1 = a3 - z1, c2 = c1 - z2, c3 = c2 - z3.
  - z1 <= a3, z2 <= c1, z3 <= c2.
  - Output registers load from c3.
- Output scaling: c3 arithmetic-shifted right by 3*LOG2R - 8, then saturated to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1], i.e. -128..127 by default.
- out_valid is high exactly in the cycle after the strobe edge. i_out and q_out hold between strobes.
- Latency: 1 cycle from strobe sample to out_valid. The first 3 outputs after reset or lo_sync are CIC transients; outputs from the 4th strobe onward are steady-state.
- in_valid low: nothing advances, out_valid stays 0, outputs hold.
- lo_sync without in_valid is ignored.

Test Plan:
- Repeating pattern +1, 0, -1, 0 (codes 01, 00, 11, 00), lo_sync on the first sample, in_valid continuous -> from the 4th out_valid: i_out = 127 (128 saturated), q_out = 0; out_valid every 16 cycles, 1 cycle wide.
- Pattern -1, 0, +1, 0 -> steady i_out = -128, q_out = 0. Pattern 0, +1, 0, -1 -> i_out = 0, q_out = 127.
- Constant +1 (all 01) -> steady i_out = 0, q_out = 0. Pattern +1, 0, 0, 0 -> i_out = 64, q_out = 0.
- in_valid toggled 1/0 every cycle with the first pattern -> same steady values; out_valid spacing 32 cycles.
- Inject one 2'b10 -> code_err = 1 next cycle and stays set; err_clr together with another 2'b10 -> remains 1; err_clr alone -> 0.
- Assert reset low mid-block (sample 7 of 16) -> all outputs 0 immediately. After release, no out_valid before 16 accepted samples; steady values are restored by the 4th strobe.
